spi_xfer_arbiter: RTL and testbench

Sequencing and arbitration controller in front of `spi_core`. Two requesters each submit single-word SPI transfers. The block grants the core to one of them with round-robin fairness and drives a per-requester active-low slave select with programmable setup and hold. It then strobes the core's write and read ports and returns the received word. Optional locked bursts keep slave select asserted across several words, capped at a maximum length.

---
 rtl/spi_xfer_arbiter.sv | 169 ++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_arbiter.sv
// Two-requester round-robin front end for spi_core: drives per-requester ss_n with
// programmable setup/hold, strobes the core write/read ports, and supports capped locked bursts.
module spi_xfer_arbiter #(
  parameter int DWIDTH    = 8,
  parameter int SS_SETUP  = 2,
  parameter int SS_HOLD   = 2,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [DWIDTH-1:0] wdat0,
  input  logic [DWIDTH-1:0] wdat1,
  output logic              ack0,
  output logic              ack1,
  output logic [DWIDTH-1:0] rdat0,
  output logic [DWIDTH-1:0] rdat1,
  output logic              core_cs,
  output logic              core_wr,
  output logic              core_rd,
  output logic [DWIDTH-1:0] core_din,
  input  logic [DWIDTH-1:0] core_dout,
  input  logic              core_busy,
  output logic [1:0]        ss_n
);

  localparam int DLY_MAX = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
  localparam int CW      = $clog2(DLY_MAX + 2);
  localparam int BW      = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, READ, DONE, LGAP, HOLD} state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [1:0]        ss_n_q, ss_n_d;
  logic              cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic [DWIDTH-1:0] din_q, din_d;
  logic [1:0]        ack_q, ack_d;
  logic [DWIDTH-1:0] rdat0_q, rdat0_d, rdat1_q, rdat1_d;
  logic              req_g, lock_g;

  assign req_g  = gnt_q ? req1 : req0;
  assign lock_g = gnt_q ? lock1 : lock0;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = (req0 && req1) ? ~last_q : req1;
          burst_d = '0;
          cnt_d   = '0;
          state_d = (SS_SETUP == 0) ? ISSUE : SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(SS_SETUP - 1)) state_d = ISSUE;
        else                            cnt_d   = cnt_q + CW'(1);
      end
      ISSUE: begin
        burst_d = burst_q + BW'(1);
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // cnt_q == 0 marks the first WAIT cycle, where core_busy may not have risen yet
        if (cnt_q == '0)     cnt_d   = CW'(1);
        else if (!core_busy) state_d = READ;
      end
      READ: state_d = DONE;
      DONE: begin
        cnt_d = '0;
        if (lock_g && (burst_q < BW'(MAX_BURST))) begin
          state_d = LGAP;
        end else begin
          state_d = (SS_HOLD == 0) ? IDLE : HOLD;
          if (SS_HOLD == 0) last_d = gnt_q;
        end
      end
      LGAP: begin
        cnt_d = '0;
        if (req_g) begin
          state_d = ISSUE;
        end else if (!lock_g) begin
          state_d = (SS_HOLD == 0) ? IDLE : HOLD;
          if (SS_HOLD == 0) last_d = gnt_q;
        end
      end
      HOLD: begin
        if (cnt_q == CW'(SS_HOLD - 1)) begin
          state_d = IDLE;
          last_d  = gnt_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered images of the next state so every port is a flop.
    ss_n_d = 2'b11;
    if (state_d != IDLE) ss_n_d[gnt_d] = 1'b0;
    cs_d   = (state_d == ISSUE) || (state_d == READ);
    wr_d   = (state_d == ISSUE);
    rd_d   = (state_d == READ);
    din_d  = (state_d == ISSUE) ? (gnt_d ? wdat1 : wdat0) : din_q;
    ack_d  = 2'b00;
    if (state_d == DONE) ack_d[gnt_d] = 1'b1;
    rdat0_d = rdat0_q;
    rdat1_d = rdat1_q;
    if (state_q == READ) begin
      if (gnt_q) rdat1_d = core_dout;
      else       rdat0_d = core_dout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      burst_q <= '0;
      ss_n_q  <= 2'b11;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      din_q   <= '0;
      ack_q   <= 2'b00;
      rdat0_q <= '0;
      rdat1_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      ss_n_q  <= ss_n_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      rdat0_q <= rdat0_d;
      rdat1_q <= rdat1_d;
    end
  end

  assign ss_n     = ss_n_q;
  assign core_cs  = cs_q;
  assign core_wr  = wr_q;
  assign core_rd  = rd_q;
  assign core_din = din_q;
  assign ack0     = ack_q[0];
  assign ack1     = ack_q[1];
  assign rdat0    = rdat0_q;
  assign rdat1    = rdat1_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter: instance A (setup/hold 2, burst cap 4) and
// instance Z (zero setup/hold), each with a loopback core model busy for B cycles.
module tb_spi_xfer_arbiter;
  localparam int B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int npass = 0;
  int ntot  = 0;

  logic [1:0] a_req, a_lock, a_ack, a_ss;
  logic [7:0] a_wdat0, a_wdat1, a_rdat0, a_rdat1, a_din, a_dout;
  logic       a_cs, a_wr, a_rd, a_busy;
  logic [1:0] z_req, z_lock, z_ack, z_ss;
  logic [7:0] z_wdat0, z_wdat1, z_rdat0, z_rdat1, z_din, z_dout;
  logic       z_cs, z_wr, z_rd, z_busy;

  spi_xfer_arbiter #(.DWIDTH(8), .SS_SETUP(2), .SS_HOLD(2), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst(rst), .req0(a_req[0]), .req1(a_req[1]), .lock0(a_lock[0]), .lock1(a_lock[1]),
    .wdat0(a_wdat0), .wdat1(a_wdat1), .ack0(a_ack[0]), .ack1(a_ack[1]), .rdat0(a_rdat0), .rdat1(a_rdat1),
    .core_cs(a_cs), .core_wr(a_wr), .core_rd(a_rd), .core_din(a_din), .core_dout(a_dout),
    .core_busy(a_busy), .ss_n(a_ss));

  spi_xfer_arbiter #(.DWIDTH(8), .SS_SETUP(0), .SS_HOLD(0), .MAX_BURST(16)) u_dut_z (
    .clk(clk), .rst(rst), .req0(z_req[0]), .req1(z_req[1]), .lock0(z_lock[0]), .lock1(z_lock[1]),
    .wdat0(z_wdat0), .wdat1(z_wdat1), .ack0(z_ack[0]), .ack1(z_ack[1]), .rdat0(z_rdat0), .rdat1(z_rdat1),
    .core_cs(z_cs), .core_wr(z_wr), .core_rd(z_rd), .core_din(z_din), .core_dout(z_dout),
    .core_busy(z_busy), .ss_n(z_ss));

  // Core models: busy for exactly B cycles starting the cycle after the write strobe.
  int a_cnt, z_cnt;
  always @(posedge clk or negedge rst)
    if (!rst) begin a_cnt <= 0; a_busy <= 1'b0; a_dout <= '0; end
    else if (a_cs && a_wr) begin a_cnt <= B; a_busy <= 1'b1; a_dout <= a_din; end
    else if (a_cnt > 0) begin a_cnt <= a_cnt - 1; a_busy <= (a_cnt > 1); end
  always @(posedge clk or negedge rst)
    if (!rst) begin z_cnt <= 0; z_busy <= 1'b0; z_dout <= '0; end
    else if (z_cs && z_wr) begin z_cnt <= B; z_busy <= 1'b1; z_dout <= z_din; end
    else if (z_cnt > 0) begin z_cnt <= z_cnt - 1; z_busy <= (z_cnt > 1); end

  int   ord[$];
  bit   both_low = 0, dual_ack = 0;
  int   a_wr_cyc = -1, z_wr_cyc = -1, a_wr_n = 0, a_ack_n = 0, a_rise0 = -1, a_rise1_n = 0;
  logic [1:0] a_ss_prev = 2'b11;
  always @(negedge clk) begin
    if (a_ss === 2'b00 || z_ss === 2'b00) both_low = 1;
    if (a_ack === 2'b11) dual_ack = 1;
    if (a_ack[0]) ord.push_back(0);
    if (a_ack[1]) ord.push_back(1);
    if (a_ack != 2'b00) a_ack_n++;
    if (a_wr) begin a_wr_cyc = cyc; a_wr_n++; end
    if (z_wr) z_wr_cyc = cyc;
    if (!a_ss_prev[0] && a_ss[0]) a_rise0 = cyc;
    if (!a_ss_prev[1] && a_ss[1]) a_rise1_n++;
    a_ss_prev = a_ss;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Raise a request on instance A and wait for its ack; optionally drop req/lock after it.
  task automatic a_send(input bit r, input logic [7:0] d, input bit lk, input bit drop,
                        output int at, output logic [7:0] rd, output logic [1:0] ss);
    if (r) begin a_wdat1 = d; a_lock[1] = lk; a_req[1] = 1'b1; end
    else   begin a_wdat0 = d; a_lock[0] = lk; a_req[0] = 1'b1; end
    at = -1; rd = '0; ss = 2'b11;
    for (int t = 0; t < 400 && at < 0; t++) begin
      @(negedge clk);
      if (a_ack[r]) begin at = cyc; rd = r ? a_rdat1 : a_rdat0; ss = a_ss; end
    end
    chk("ack_seen", 32'(at >= 0), 1);
    if (drop) begin a_req[r] = 1'b0; a_lock[r] = 1'b0; end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, t, at0, at1, at2, at3, at4, at5, atb, rc, w2, w3, acks;
    logic [7:0] rd, rd5, rdb;
    logic [1:0] ss, ssb;

    rst = 1'b0;
    a_req = '0; a_lock = '0; a_wdat0 = '0; a_wdat1 = '0;
    z_req = '0; z_lock = '0; z_wdat0 = '0; z_wdat1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_ss", a_ss, 2'b11);
    chk("rst_z_ss", z_ss, 2'b11);
    chk("rst_a_strobes", {a_cs, a_wr, a_rd}, 3'b000);
    chk("rst_z_strobes", {z_cs, z_wr, z_rd}, 3'b000);
    chk("rst_acks", {a_ack, z_ack}, 4'b0000);
    chk("rst_a_din", a_din, 8'h00);
    chk("rst_a_rdat", {a_rdat0, a_rdat1}, 16'h0000);
    chk("rst_z_rdat", {z_rdat0, z_rdat1}, 16'h0000);
    rst = 1'b1;

    // Single transfer: cycle indices below are edge counts, one less than the spec's cycle numbers.
    @(negedge clk);
    a_wdat0 = 8'hA5; a_req[0] = 1'b1;
    @(posedge clk); #1 n = cyc;
    @(negedge clk);
    chk("t1_ss_low", a_ss, 2'b10);
    t = 0;
    while (!a_ack[0] && t < 100) begin @(negedge clk); t++; end
    chk("t1_ack_cyc", cyc, n + 21);
    chk("t1_rdat0", a_rdat0, 8'hA5);
    chk("t1_wr_cyc", a_wr_cyc, n + 2);
    chk("t1_din", a_din, 8'hA5);
    a_req[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_ss_hold", a_ss, 2'b10);
    @(negedge clk);
    chk("t1_ss_release", a_ss, 2'b11);
    repeat (2) @(negedge clk);
    chk("t1_wr_count", a_wr_n, 1);
    chk("t1_rdat0_held", a_rdat0, 8'hA5);

    // Simultaneous requests right after reset: strict alternation starting with 0.
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    ord.delete();
    fork
      begin
        a_send(1'b0, 8'h10, 1'b0, 1'b1, at0, rd, ss);
        chk("t2_r0_rdat_a", rd, 8'h10); chk("t2_r0_ss_a", ss, 2'b10);
        @(negedge clk);
        a_send(1'b0, 8'h12, 1'b0, 1'b1, at0, rd, ss);
        chk("t2_r0_rdat_b", rd, 8'h12);
      end
      begin
        a_send(1'b1, 8'h20, 1'b0, 1'b1, at1, rdb, ssb);
        chk("t2_r1_rdat_a", rdb, 8'h20); chk("t2_r1_ss_a", ssb, 2'b01);
        @(negedge clk);
        a_send(1'b1, 8'h22, 1'b0, 1'b1, at1, rdb, ssb);
        chk("t2_r1_rdat_b", rdb, 8'h22);
      end
    join
    repeat (2) @(negedge clk);
    chk("t2_ack_count", ord.size(), 4);
    if (ord.size() == 4) chk("t2_order", {ord[0][3:0], ord[1][3:0], ord[2][3:0], ord[3][3:0]}, 16'h0101);

    // Locked burst of three words on requester 1.
    a_send(1'b1, 8'h11, 1'b1, 1'b0, at1, rd, ss);
    chk("t3_rdat_1", rd, 8'h11);
    rc = a_rise1_n;
    a_send(1'b1, 8'h22, 1'b1, 1'b0, at2, rd, ss);
    w2 = a_wr_cyc;
    chk("t3_rdat_2", rd, 8'h22);
    chk("t3_ss_2", ss, 2'b01);
    a_send(1'b1, 8'h33, 1'b1, 1'b1, at3, rd, ss);
    w3 = a_wr_cyc;
    chk("t3_rdat_3", rd, 8'h33);
    chk("t3_no_setup_2", w2, at1 + 2);
    chk("t3_no_setup_3", w3, at2 + 2);
    chk("t3_ack_spacing", at3 - at2, B + 5);
    chk("t3_ss_never_rose", a_rise1_n, rc);

    // Burst cap of 4: requester 0 stays locked, requester 1 must win after the 4th word.
    repeat (5) @(negedge clk);
    ord.delete();
    a_send(1'b0, 8'h01, 1'b1, 1'b0, at0, rd, ss);
    a_wdat1 = 8'h77; a_lock[1] = 1'b0; a_req[1] = 1'b1;
    a_send(1'b0, 8'h02, 1'b1, 1'b0, at0, rd, ss);
    a_send(1'b0, 8'h03, 1'b1, 1'b0, at0, rd, ss);
    a_send(1'b0, 8'h04, 1'b1, 1'b0, at4, rd, ss);
    chk("t4_rdat_4", rd, 8'h04);
    fork
      a_send(1'b0, 8'h05, 1'b1, 1'b1, at5, rd5, ss);
      a_send(1'b1, 8'h77, 1'b0, 1'b1, atb, rdb, ssb);
    join
    chk("t4_ss0_release", a_rise0, at4 + 3);
    chk("t4_r1_ack_cyc", atb, at4 + 25);
    chk("t4_r1_before_r0", 32'(atb < at5), 1);
    chk("t4_r1_rdat", rdb, 8'h77);
    chk("t4_r1_ss", ssb, 2'b01);
    chk("t4_r0_rdat_5", rd5, 8'h05);
    repeat (2) @(negedge clk);
    chk("t4_ack_count", ord.size(), 6);
    if (ord.size() == 6)
      chk("t4_order", {ord[0][3:0], ord[1][3:0], ord[2][3:0], ord[3][3:0], ord[4][3:0], ord[5][3:0]}, 24'h000010);

    // Zero setup and hold on instance Z.
    @(negedge clk);
    z_wdat0 = 8'h3C; z_req[0] = 1'b1;
    @(posedge clk); #1 n = cyc;
    t = 0;
    @(negedge clk);
    while (!z_ack[0] && t < 100) begin @(negedge clk); t++; end
    chk("t5_ack_cyc", cyc, n + B + 3);
    chk("t5_wr_cyc", z_wr_cyc, n);
    chk("t5_rdat0", z_rdat0, 8'h3C);
    chk("t5_ss_at_ack", z_ss, 2'b10);
    z_req[0] = 1'b0;
    @(negedge clk);
    chk("t5_ss_release", z_ss, 2'b11);

    // Reset while the core is busy.
    repeat (3) @(negedge clk);
    a_wdat0 = 8'hC3; a_req[0] = 1'b1;
    t = 0;
    while (!a_wr && t < 100) begin @(negedge clk); t++; end
    chk("t6_wr_seen", a_wr, 1'b1);
    repeat (3) @(negedge clk);
    acks = a_ack_n;
    rst = 1'b0;
    #1;
    chk("t6_ss", a_ss, 2'b11);
    chk("t6_strobes", {a_cs, a_wr, a_rd}, 3'b000);
    chk("t6_ack", a_ack, 2'b00);
    chk("t6_rdat0", a_rdat0, 8'h00);
    a_req[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("t6_no_ack", a_ack_n, acks);
    a_send(1'b0, 8'h5A, 1'b0, 1'b1, at0, rd, ss);
    chk("t6_after_rdat", rd, 8'h5A);
    chk("t6_after_ss", ss, 2'b10);

    repeat (5) @(negedge clk);
    chk("ss_never_both_low", both_low, 1'b0);
    chk("never_dual_ack", dual_ack, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
